hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/riscv_pkg.sv | 10 +
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/sb_pend_cnt.sv | 38 +++
 rtl/hazard_scoreboard.sv | 66 ++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file constants and the scoreboard pending-counter type
//   REG_IDX_W  : architectural register index width
//   NUM_REGS   : number of architectural registers (x0..x31)
//   pend_cnt_t : default-width per-register pending-write counter
package riscv_pkg;
   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS = 32;
   localparam int PEND_CNT_W = 2;
   typedef logic [PEND_CNT_W-1:0] pend_cnt_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode/writeback request bundle and scoreboard status
//   decode    : DE_V, DE_RS1/2, DE_RS1/2_USE, DE_RD, DE_RD_WEN
//   writeback : WB_V, WB_DR, WB_REG_WEN
//   status    : STALL, ISSUE (combinational); BUSY_MASK, STALL_CNT, SB_ERR (registered)
//   master drives requests, slave (the scoreboard) drives status
interface hazard_scoreboard_if;
   import riscv_pkg::*;
   logic                 DE_V;
   logic [REG_IDX_W-1:0] DE_RS1;
   logic [REG_IDX_W-1:0] DE_RS2;
   logic                 DE_RS1_USE;
   logic                 DE_RS2_USE;
   logic [REG_IDX_W-1:0] DE_RD;
   logic                 DE_RD_WEN;
   logic                 WB_V;
   logic [REG_IDX_W-1:0] WB_DR;
   logic                 WB_REG_WEN;
   logic                 STALL;
   logic                 ISSUE;
   logic [NUM_REGS-1:0]  BUSY_MASK;
   logic [15:0]          STALL_CNT;
   logic                 SB_ERR;
   modport master (
      output DE_V, DE_RS1, DE_RS2, DE_RS1_USE, DE_RS2_USE, DE_RD, DE_RD_WEN,
      output WB_V, WB_DR, WB_REG_WEN,
      input  STALL, ISSUE, BUSY_MASK, STALL_CNT, SB_ERR
   );
   modport slave (
      input  DE_V, DE_RS1, DE_RS2, DE_RS1_USE, DE_RS2_USE, DE_RD, DE_RD_WEN,
      input  WB_V, WB_DR, WB_REG_WEN,
      output STALL, ISSUE, BUSY_MASK, STALL_CNT, SB_ERR
   );
endinterface

// File: rtl/sb_pend_cnt.sv
// sb_pend_cnt: one register's pending-write counter with inc/dec/hold and misuse detection
//   CLK, RESET_N : clock, async active-low reset
//   inc, dec     : issue / retire strobes for this register
//   cnt          : current pending count
//   busy         : registered cnt != 0
//   err          : combinational, this cycle attempts overflow or underflow
module sb_pend_cnt #(
   parameter int CNT_W = 2,
   parameter int MAX_PEND = 3
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             err
);
   logic             at_max;
   logic             at_zero;
   logic [CNT_W-1:0] cnt_nxt;
   // Simultaneous inc and dec cancel, so only a lone strobe can misbehave.
   always_comb begin
      at_max = cnt == CNT_W'(MAX_PEND);
      at_zero = cnt == '0;
      err = (inc && !dec && at_max) || (dec && !inc && at_zero);
      cnt_nxt = (inc && !dec && !at_max) ? cnt + CNT_W'(1) :
                (dec && !inc && !at_zero) ? cnt - CNT_W'(1) : cnt;
   end
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         cnt <= '0;
         busy <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         busy <= cnt_nxt != '0;
      end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write scoreboard producing decode stall/issue
//   CLK, RESET_N : clock, async active-low reset
//   sb (slave)   : decode/writeback requests in, STALL/ISSUE/BUSY_MASK/STALL_CNT/SB_ERR out
//   SB_WB_BYPASS_EN : when defined, a source whose last pending write retires this
//                     cycle is not treated as a hazard
module hazard_scoreboard
   import riscv_pkg::*;
#(
   parameter int CNT_W = $bits(pend_cnt_t),
   parameter int MAX_PEND = 3
) (
   input logic              CLK,
   input logic              RESET_N,
   hazard_scoreboard_if.slave sb
);
   logic [CNT_W-1:0]    pend [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:1] inc;
   logic [NUM_REGS-1:1] dec;
   logic [NUM_REGS-1:1] err;
   logic                wb_wr;
   logic                byp1;
   logic                byp2;
   logic                raw1;
   logic                raw2;
   logic                strc;
   assign pend[0] = '0;
   assign busy[0] = 1'b0;
   assign sb.BUSY_MASK = busy;
   always_comb begin
      wb_wr = sb.WB_V && sb.WB_REG_WEN;
`ifdef SB_WB_BYPASS_EN
      byp1 = wb_wr && sb.WB_DR == sb.DE_RS1 && pend[sb.DE_RS1] == CNT_W'(1);
      byp2 = wb_wr && sb.WB_DR == sb.DE_RS2 && pend[sb.DE_RS2] == CNT_W'(1);
`else
      byp1 = 1'b0;
      byp2 = 1'b0;
`endif
      raw1 = sb.DE_RS1_USE && sb.DE_RS1 != '0 && pend[sb.DE_RS1] != '0 && !byp1;
      raw2 = sb.DE_RS2_USE && sb.DE_RS2 != '0 && pend[sb.DE_RS2] != '0 && !byp2;
      strc = sb.DE_RD_WEN && sb.DE_RD != '0 && pend[sb.DE_RD] == CNT_W'(MAX_PEND);
      sb.STALL = sb.DE_V && (raw1 || raw2 || strc);
      sb.ISSUE = sb.DE_V && !sb.STALL;
   end
   for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
      assign inc[r] = sb.ISSUE && sb.DE_RD_WEN && sb.DE_RD == REG_IDX_W'(r);
      assign dec[r] = wb_wr && sb.WB_DR == REG_IDX_W'(r);
      sb_pend_cnt #(.CNT_W(CNT_W), .MAX_PEND(MAX_PEND)) u_cnt (
         .CLK    (CLK),
         .RESET_N(RESET_N),
         .inc    (inc[r]),
         .dec    (dec[r]),
         .cnt    (pend[r]),
         .busy   (busy[r]),
         .err    (err[r])
      );
   end
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         sb.STALL_CNT <= '0;
         sb.SB_ERR <= 1'b0;
      end else begin
         sb.STALL_CNT <= (sb.STALL && sb.STALL_CNT != 16'hFFFF) ? sb.STALL_CNT + 16'd1 : sb.STALL_CNT;
         sb.SB_ERR <= sb.SB_ERR || (|err);
      end
endmodule
